// File: rtl/spi_bridge_pkg.sv
// Shared types for the SPI register front end to peripheral bus bridge:
// FSM state encoding and the bus width codes.
package spi_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        READ_HOLD = 2'd3
    } bridge_state_t;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;
    localparam logic [1:0] WIDTH_NONE = 2'b11;

endpackage

// File: rtl/spi_periph_bridge.sv
// Bridges SPI register-front-end strobes onto a width-coded peripheral bus,
// with a bounded read wait and a sticky timeout flag.
//
// state     | meaning
// IDLE      | waiting for a write strobe or a rising read request
// WRITE     | data_write_n driven with the captured width for one cycle
// READ_WAIT | data_read_n driven until data_ready or timeout
// READ_HOLD | result held until the front end drops reg_addr_v
module spi_periph_bridge
    import spi_bridge_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int REG_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic              reg_addr_v,
    input  logic [REG_W-1:0]  reg_data_o,
    input  logic              reg_data_o_dv,
    input  logic [1:0]        txn_width,
    output logic [REG_W-1:0]  reg_data_i,
    output logic [ADDR_W-1:0] address,
    output logic [REG_W-1:0]  data_in,
    output logic [1:0]        data_write_n,
    output logic [1:0]        data_read_n,
    input  logic [REG_W-1:0]  data_out,
    input  logic              data_ready,
    output logic              timeout_err
);

    localparam logic [7:0]       TMO_CNT   = 8'(TIMEOUT);
    localparam logic [REG_W-1:0] MASK_BYTE = REG_W'(8'hFF);
    localparam logic [REG_W-1:0] MASK_HALF = REG_W'(16'hFFFF);

    bridge_state_t    state;
    logic [1:0]       width;
    logic [7:0]       cnt;
    logic             addr_v_q;
    logic             rd_rise;
    logic             wr_req;
    logic             rd_req;
    logic [7:0]       cnt_nxt;
    logic [REG_W-1:0] rd_masked;

    // Reads start only on the first cycle of reg_addr_v so a held strobe
    // cannot re-trigger after the bridge returns to IDLE.
    assign rd_rise = reg_addr_v & ~addr_v_q;
    assign wr_req  = reg_data_o_dv && (txn_width != WIDTH_NONE);
    assign rd_req  = rd_rise && (txn_width != WIDTH_NONE);
    assign cnt_nxt = cnt + 8'd1;

    always_comb begin
        rd_masked = data_out;
        case (width)
            WIDTH_BYTE: rd_masked = data_out & MASK_BYTE;
            WIDTH_HALF: rd_masked = data_out & MASK_HALF;
            default:    rd_masked = data_out;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state        <= IDLE;
            width        <= WIDTH_NONE;
            cnt          <= 8'd0;
            addr_v_q     <= 1'b0;
            address      <= '0;
            data_in      <= '0;
            data_write_n <= WIDTH_NONE;
            data_read_n  <= WIDTH_NONE;
            reg_data_i   <= '0;
            timeout_err  <= 1'b0;
        end else if (ena) begin
            addr_v_q <= reg_addr_v;
            case (state)
                IDLE: begin
                    // A write in the same cycle as a read request wins.
                    if (wr_req) begin
                        state        <= WRITE;
                        address      <= reg_addr;
                        data_in      <= reg_data_o;
                        width        <= txn_width;
                        data_write_n <= txn_width;
                    end else if (rd_req) begin
                        state       <= READ_WAIT;
                        address     <= reg_addr;
                        width       <= txn_width;
                        data_read_n <= txn_width;
                        cnt         <= 8'd0;
                    end
                end
                WRITE: begin
                    data_write_n <= WIDTH_NONE;
                    state        <= IDLE;
                end
                READ_WAIT: begin
                    // data_ready in the final allowed cycle still counts as success.
                    if (data_ready) begin
                        reg_data_i  <= rd_masked;
                        timeout_err <= 1'b0;
                        data_read_n <= WIDTH_NONE;
                        state       <= READ_HOLD;
                    end else if (cnt_nxt == TMO_CNT) begin
                        cnt         <= cnt_nxt;
                        reg_data_i  <= '0;
                        timeout_err <= 1'b1;
                        data_read_n <= WIDTH_NONE;
                        state       <= READ_HOLD;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                READ_HOLD: begin
                    if (!reg_addr_v) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_periph_bridge.sv
// Randomized self-checking bench for spi_periph_bridge against a
// transaction-level model of the bridge's read/write rules.
module tb_spi_periph_bridge;

    localparam int ADDR_W = 6;
    localparam int REG_W  = 32;
    localparam int TMO    = 4;

    logic              clk;
    logic              rstb;
    logic              ena;
    logic [ADDR_W-1:0] reg_addr;
    logic              reg_addr_v;
    logic [REG_W-1:0]  reg_data_o;
    logic              reg_data_o_dv;
    logic [1:0]        txn_width;
    logic [REG_W-1:0]  reg_data_i;
    logic [ADDR_W-1:0] address;
    logic [REG_W-1:0]  data_in;
    logic [1:0]        data_write_n;
    logic [1:0]        data_read_n;
    logic [REG_W-1:0]  data_out;
    logic              data_ready;
    logic              timeout_err;

    spi_periph_bridge #(.ADDR_W(ADDR_W), .REG_W(REG_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rstb(rstb), .ena(ena),
        .reg_addr(reg_addr), .reg_addr_v(reg_addr_v),
        .reg_data_o(reg_data_o), .reg_data_o_dv(reg_data_o_dv),
        .txn_width(txn_width), .reg_data_i(reg_data_i),
        .address(address), .data_in(data_in),
        .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(data_out), .data_ready(data_ready),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Peripheral responder and bus monitor
    int rd_delay     = 0;
    int rd_cycles    = 0;
    int last_rd_len  = 0;
    int read_starts  = 0;
    int write_cycles = 0;

    always @(negedge clk) begin
        if (data_read_n != 2'b11) begin
            if (rd_cycles == 0) read_starts = read_starts + 1;
            rd_cycles   = rd_cycles + 1;
            last_rd_len = rd_cycles;
            data_ready  = (rd_delay != 0) && (rd_cycles == rd_delay);
        end else begin
            rd_cycles  = 0;
            data_ready = 1'b0;
        end
        if (data_write_n != 2'b11) write_cycles = write_cycles + 1;
    end

    // Model state
    logic [REG_W-1:0] exp_rdata = '0;
    logic             exp_err   = 1'b0;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [REG_W-1:0] model_mask(input logic [1:0] w, input logic [REG_W-1:0] d);
        if (w == 2'b00) return d % 256;
        if (w == 2'b01) return d % 65536;
        return d;
    endfunction

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [REG_W-1:0] d, input logic [1:0] w);
        int wc0, rs0;
        logic [1:0] exp_wn;
        wc0 = write_cycles;
        rs0 = read_starts;
        exp_wn = w;
        reg_addr = a; reg_data_o = d; txn_width = w; reg_data_o_dv = 1'b1;
        step();
        reg_data_o_dv = 1'b0;
        reg_data_o = $urandom;
        txn_width = 2'($urandom);
        n_checks++;
        if (data_write_n !== exp_wn) begin
            n_fail++; $display("FAIL write_strobe: data_write_n=%b expected %b", data_write_n, exp_wn);
        end
        if (w != 2'b11) begin
            n_checks++;
            if (address !== a || data_in !== d) begin
                n_fail++; $display("FAIL write_capture: address=%h data_in=%h expected %h %h", address, data_in, a, d);
            end
        end
        step();
        step();
        n_checks++;
        if (data_write_n !== 2'b11 || (write_cycles - wc0) != ((w != 2'b11) ? 1 : 0) || read_starts != rs0) begin
            n_fail++; $display("FAIL write_len: data_write_n=%b cycles=%0d reads=%0d expected 11 %0d 0",
                               data_write_n, write_cycles - wc0, read_starts - rs0, (w != 2'b11) ? 1 : 0);
        end
        n_checks++;
        if (reg_data_i !== exp_rdata) begin
            n_fail++; $display("FAIL write_rdata: reg_data_i=%h expected %h", reg_data_i, exp_rdata);
        end
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [1:0] w, input logic [REG_W-1:0] d, input int delay);
        int rs0, exp_len;
        rs0 = read_starts;
        data_out = d; rd_delay = delay; reg_addr = a; txn_width = w; reg_addr_v = 1'b1;
        step();
        txn_width = 2'($urandom);
        reg_addr = 6'($urandom);
        if (w != 2'b11) begin
            n_checks++;
            if (data_read_n !== w || address !== a) begin
                n_fail++; $display("FAIL read_start: data_read_n=%b address=%h expected %b %h", data_read_n, address, w, a);
            end
        end
        repeat (TMO + 3) step();
        reg_addr_v = 1'b0;
        repeat (3) step();
        exp_len = 0;
        if (w != 2'b11) begin
            if (delay >= 1 && delay <= TMO) begin
                exp_rdata = model_mask(w, d); exp_err = 1'b0; exp_len = delay;
            end else begin
                exp_rdata = '0; exp_err = 1'b1; exp_len = TMO;
            end
            n_checks++;
            if (last_rd_len != exp_len) begin
                n_fail++; $display("FAIL read_len: strobe cycles=%0d expected %0d", last_rd_len, exp_len);
            end
        end
        n_checks++;
        if ((read_starts - rs0) != ((w != 2'b11) ? 1 : 0) || data_read_n !== 2'b11) begin
            n_fail++; $display("FAIL read_count: reads=%0d data_read_n=%b expected %0d 11",
                               read_starts - rs0, data_read_n, (w != 2'b11) ? 1 : 0);
        end
        n_checks++;
        if (reg_data_i !== exp_rdata || timeout_err !== exp_err) begin
            n_fail++; $display("FAIL read_result: reg_data_i=%h err=%b expected %h %b", reg_data_i, timeout_err, exp_rdata, exp_err);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (data_write_n !== 2'b11 || data_read_n !== 2'b11 || reg_data_i !== '0 ||
            timeout_err !== 1'b0 || address !== '0 || data_in !== '0) begin
            n_fail++; $display("FAIL reset_values: wn=%b rn=%b rd=%h err=%b addr=%h din=%h expected 11 11 0 0 0 0",
                               data_write_n, data_read_n, reg_data_i, timeout_err, address, data_in);
        end
    endtask

    task automatic test_write_word();
        do_write(6'h05, 32'hDEADBEEF, 2'b10);
        do_write(6'h3F, 32'h0000_00A5, 2'b00);
        do_write(6'h11, 32'h1234_5678, 2'b11);
    endtask

    task automatic test_read_byte();
        do_read(6'h0A, 2'b00, 32'h1234_5678, 3);
        do_read(6'h0B, 2'b01, 32'hCAFE_F00D, 1);
        do_read(6'h0C, 2'b10, 32'h8765_4321, TMO);
    endtask

    task automatic test_timeout();
        do_read(6'h21, 2'b10, 32'hFFFF_FFFF, 0);
        do_write(6'h22, 32'h5555_AAAA, 2'b10);
        n_checks++;
        if (timeout_err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_sticky: timeout_err=%b expected 1", timeout_err);
        end
        do_read(6'h23, 2'b01, 32'hABCD_1234, 2);
    endtask

    task automatic test_collision();
        int wc0, rs0;
        wc0 = write_cycles; rs0 = read_starts;
        reg_addr = 6'h15; reg_data_o = 32'h0BAD_F00D; txn_width = 2'b10;
        data_out = 32'h7777_7777; rd_delay = 1;
        reg_data_o_dv = 1'b1; reg_addr_v = 1'b1;
        step();
        reg_data_o_dv = 1'b0;
        repeat (5) step();
        reg_addr_v = 1'b0;
        repeat (2) step();
        n_checks++;
        if ((write_cycles - wc0) != 1 || read_starts != rs0 || reg_data_i !== exp_rdata) begin
            n_fail++; $display("FAIL collision: writes=%0d reads=%0d rd=%h expected 1 0 %h",
                               write_cycles - wc0, read_starts - rs0, reg_data_i, exp_rdata);
        end
    endtask

    task automatic test_ena();
        int wc0;
        wc0 = write_cycles;
        ena = 1'b0;
        reg_addr = 6'h01; reg_data_o = 32'h1111_2222; txn_width = 2'b01; reg_data_o_dv = 1'b1;
        step();
        reg_data_o_dv = 1'b0;
        ena = 1'b1;
        step();
        n_checks++;
        if (write_cycles != wc0 || data_write_n !== 2'b11) begin
            n_fail++; $display("FAIL ena_gate: writes=%0d wn=%b expected 0 11", write_cycles - wc0, data_write_n);
        end
        reg_data_o_dv = 1'b1;
        step();
        reg_data_o_dv = 1'b0;
        ena = 1'b0;
        repeat (3) step();
        n_checks++;
        if (data_write_n !== 2'b01) begin
            n_fail++; $display("FAIL ena_hold: data_write_n=%b expected 01", data_write_n);
        end
        ena = 1'b1;
        step();
        step();
        n_checks++;
        if (data_write_n !== 2'b11 || (write_cycles - wc0) != 4) begin
            n_fail++; $display("FAIL ena_release: wn=%b writes=%0d expected 11 4", data_write_n, write_cycles - wc0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 0)
                do_write(6'($urandom), $urandom, 2'($urandom_range(0, 3)));
            else
                do_read(6'($urandom), 2'($urandom_range(0, 3)), $urandom, $urandom_range(0, TMO + 1));
        end
    endtask

    task automatic test_reset_mid_read();
        int rs0;
        do_read(6'h2A, 2'b10, 32'hFACE_B00C, 2);
        rs0 = read_starts;
        data_out = 32'h9999_9999; rd_delay = 3; reg_addr = 6'h2B; txn_width = 2'b10; reg_addr_v = 1'b1;
        step();
        step();
        rstb = 1'b0;
        #1;
        n_checks++;
        if (data_read_n !== 2'b11 || reg_data_i !== '0 || timeout_err !== 1'b0 ||
            address !== '0 || data_in !== '0 || data_write_n !== 2'b11) begin
            n_fail++; $display("FAIL reset_async: rn=%b rd=%h err=%b addr=%h din=%h wn=%b expected reset values",
                               data_read_n, reg_data_i, timeout_err, address, data_in, data_write_n);
        end
        exp_rdata = '0; exp_err = 1'b0;
        repeat (2) step();
        reg_addr_v = 1'b0;
        rstb = 1'b1;
        repeat (4) step();
        n_checks++;
        if (data_read_n !== 2'b11 || reg_data_i !== '0 || (read_starts - rs0) != 1) begin
            n_fail++; $display("FAIL reset_abort: rn=%b rd=%h reads=%0d expected 11 0 1",
                               data_read_n, reg_data_i, read_starts - rs0);
        end
    endtask

    initial begin
        rstb = 1'b0; ena = 1'b1;
        reg_addr = '0; reg_addr_v = 1'b0; reg_data_o = '0; reg_data_o_dv = 1'b0;
        txn_width = 2'b11; data_out = '0; data_ready = 1'b0;
        repeat (3) step();
        test_reset();
        rstb = 1'b1;
        step();
        test_reset();
        test_write_word();
        test_read_byte();
        test_timeout();
        test_collision();
        test_ena();
        test_random();
        test_reset_mid_read();
        test_write_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
